// File: rtl/cmd_arb_pkg.sv
// Shared definitions for the command stream arbiter: FSM state encoding and source-count limit.
package cmd_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } arb_state_e;

    localparam int MAX_NUM_SOURCES = 8;

endpackage

// File: rtl/axis_skid_slice.sv
// Registered AXI-Stream slice: one output register plus one skid register that catches the
// beat already in flight when the consumer stalls. Skid content always drains before new input.
module axis_skid_slice #(
    parameter int DATA_WIDTH = 36
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy
);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  accept;

    assign in_ready  = !skid_valid_q;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = out_valid_q || skid_valid_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        // The output register only changes when it is empty or being consumed, which keeps it stable under stall.
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/command_stream_arbiter.sv
// Packet-atomic round-robin merge of NUM_SOURCES command streams into one registered stream.
// Define CMD_ARB_STRICT_PRIORITY_EN to make the lowest-index requester always win instead.
module command_stream_arbiter
    import cmd_arb_pkg::*;
#(
    parameter int NUM_SOURCES      = 2,
    parameter int CMD_STREAM_WIDTH = 32,
    parameter int ID_WIDTH         = 3
) (
    input  logic                                    aclk,
    input  logic                                    resetn,
    input  logic [NUM_SOURCES-1:0]                  s_cmd_axis_tvalid,
    output logic [NUM_SOURCES-1:0]                  s_cmd_axis_tready,
    input  logic [NUM_SOURCES-1:0]                  s_cmd_axis_tlast,
    input  logic [NUM_SOURCES*CMD_STREAM_WIDTH-1:0] s_cmd_axis_tdata,
    output logic                                    m_cmd_axis_tvalid,
    input  logic                                    m_cmd_axis_tready,
    output logic                                    m_cmd_axis_tlast,
    output logic [CMD_STREAM_WIDTH-1:0]             m_cmd_axis_tdata,
    output logic [ID_WIDTH-1:0]                     m_cmd_axis_tid,
    output logic                                    busy
);

    localparam int W  = CMD_STREAM_WIDTH;
    localparam int SW = W + 1 + ID_WIDTH;

    arb_state_e            state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]   rr_q, rr_d;
    logic [NUM_SOURCES-1:0] req_rot;
    logic                  found;
    logic [ID_WIDTH-1:0]   pick;
    logic                  sel_valid;
    logic                  sel_last;
    logic [W-1:0]          sel_data;
    logic                  slice_in_valid;
    logic                  slice_in_ready;
    logic                  slice_busy;
    logic [SW-1:0]         slice_out_data;
    int                    pos;

    // Rotate requests so position 0 is the rr pointer; the first set bit is the winner.
    always_comb begin
        req_rot = NUM_SOURCES'({s_cmd_axis_tvalid, s_cmd_axis_tvalid} >> rr_q);
        found   = 1'b0;
        pick    = '0;
        pos     = 0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (!found && req_rot[i]) begin
                found = 1'b1;
                pos   = int'(rr_q) + i;
                if (pos >= NUM_SOURCES) begin
                    pos = pos - NUM_SOURCES;
                end
                pick  = ID_WIDTH'(pos);
            end
        end
    end

    always_comb begin
        sel_valid         = 1'b0;
        sel_last          = 1'b0;
        sel_data          = '0;
        s_cmd_axis_tready = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                sel_valid            = s_cmd_axis_tvalid[i];
                sel_last             = s_cmd_axis_tlast[i];
                sel_data             = s_cmd_axis_tdata[i*W +: W];
                s_cmd_axis_tready[i] = (state_q == ST_STREAM) && slice_in_ready;
            end
        end
    end

    assign slice_in_valid = (state_q == ST_STREAM) && sel_valid;

    // The grant is only released by an accepted tlast beat; a new winner is chosen in the following IDLE cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (slice_in_valid && slice_in_ready && sel_last) begin
                    state_d = ST_IDLE;
`ifdef CMD_ARB_STRICT_PRIORITY_EN
                    rr_d    = '0;
`else
                    rr_d    = (grant_q == ID_WIDTH'(NUM_SOURCES - 1)) ? '0 : grant_q + ID_WIDTH'(1);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    axis_skid_slice #(
        .DATA_WIDTH(SW)
    ) u_slice (
        .aclk      (aclk),
        .resetn    (resetn),
        .in_valid  (slice_in_valid),
        .in_ready  (slice_in_ready),
        .in_data   ({grant_q, sel_last, sel_data}),
        .out_valid (m_cmd_axis_tvalid),
        .out_ready (m_cmd_axis_tready),
        .out_data  (slice_out_data),
        .busy      (slice_busy)
    );

    assign {m_cmd_axis_tid, m_cmd_axis_tlast, m_cmd_axis_tdata} = slice_out_data;
    assign busy = (state_q == ST_STREAM) || slice_busy;

endmodule

// File: tb/tb_command_stream_arbiter.sv
// Scoreboard bench for command_stream_arbiter with three sources; expected beats are queued in
// predicted arbitration order and compared as they leave the merged stream.
module tb_command_stream_arbiter;

    localparam int NS  = 3;
    localparam int W   = 32;
    localparam int IDW = 3;

    logic              aclk = 1'b0;
    logic              resetn = 1'b0;
    logic [NS-1:0]     s_tvalid;
    logic [NS-1:0]     s_tready;
    logic [NS-1:0]     s_tlast;
    logic [NS*W-1:0]   s_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic [W-1:0]      m_tdata;
    logic [IDW-1:0]    m_tid;
    logic              busy;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;
    int cycle       = 0;

    logic [32:0]   src_q0[$];
    logic [32:0]   src_q1[$];
    logic [32:0]   src_q2[$];
    logic [35:0]   exp_q[$];
    logic [NS-1:0] paused = '0;
    int            fire_cyc[$];
    int            fire_src[$];

    always #5 aclk = ~aclk;

    command_stream_arbiter #(
        .NUM_SOURCES(NS),
        .CMD_STREAM_WIDTH(W),
        .ID_WIDTH(IDW)
    ) dut (
        .aclk              (aclk),
        .resetn            (resetn),
        .s_cmd_axis_tvalid (s_tvalid),
        .s_cmd_axis_tready (s_tready),
        .s_cmd_axis_tlast  (s_tlast),
        .s_cmd_axis_tdata  (s_tdata),
        .m_cmd_axis_tvalid (m_tvalid),
        .m_cmd_axis_tready (m_tready),
        .m_cmd_axis_tlast  (m_tlast),
        .m_cmd_axis_tdata  (m_tdata),
        .m_cmd_axis_tid    (m_tid),
        .busy              (busy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int src, input logic [31:0] base, input int len);
        for (int k = 0; k < len; k++) begin
            logic [32:0] beat;
            beat = {(k == len - 1), base + 32'(k)};
            case (src)
                0:       src_q0.push_back(beat);
                1:       src_q1.push_back(beat);
                default: src_q2.push_back(beat);
            endcase
        end
    endtask

    task automatic expectPacket(input int src, input logic [31:0] base, input int len);
        for (int k = 0; k < len; k++) begin
            exp_q.push_back({IDW'(src), (k == len - 1), base + 32'(k)});
        end
    endtask

    task automatic waitIdle(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge aclk);
            #2;
            done = (src_q0.size() == 0) && (src_q1.size() == 0) && (src_q2.size() == 0)
                   && (exp_q.size() == 0) && !busy;
        end
        checkOutput({tag, "_drain"}, 64'(done), 64'd1);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_s_tready"}, 64'(s_tready), 64'd0);
        checkOutput({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
        checkOutput({tag, "_m_tlast"},  64'(m_tlast),  64'd0);
        checkOutput({tag, "_m_tid"},    64'(m_tid),    64'd0);
        checkOutput({tag, "_busy"},     64'(busy),     64'd0);
    endtask

    // Source drivers: pop a beat after each handshake and present the next one.
    initial begin
        logic [NS-1:0] fire;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        forever begin
            @(negedge aclk);
            fire = s_tvalid & s_tready;
            @(posedge aclk);
            cycle++;
            #1;
            if (fire[0] && src_q0.size() > 0) begin
                fire_cyc.push_back(cycle); fire_src.push_back(0); void'(src_q0.pop_front());
            end
            if (fire[1] && src_q1.size() > 0) begin
                fire_cyc.push_back(cycle); fire_src.push_back(1); void'(src_q1.pop_front());
            end
            if (fire[2] && src_q2.size() > 0) begin
                fire_cyc.push_back(cycle); fire_src.push_back(2); void'(src_q2.pop_front());
            end
            s_tvalid[0] = !paused[0] && (src_q0.size() > 0);
            s_tvalid[1] = !paused[1] && (src_q1.size() > 0);
            s_tvalid[2] = !paused[2] && (src_q2.size() > 0);
            if (src_q0.size() > 0) {s_tlast[0], s_tdata[31:0]}  = src_q0[0];
            if (src_q1.size() > 0) {s_tlast[1], s_tdata[63:32]} = src_q1[0];
            if (src_q2.size() > 0) {s_tlast[2], s_tdata[95:64]} = src_q2[0];
        end
    end

    // Output monitor: every valid cycle must show the head of the scoreboard, stalled or not.
    initial begin
        forever begin
            @(negedge aclk);
            if (resetn && m_tvalid) begin
                checkOutput("beat_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    checkOutput("out_beat", 64'({m_tid, m_tlast, m_tdata}), 64'(exp_q[0]));
                    if (m_tready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit          seen;
        logic [4:0]  pat;
        m_tready = 1'b1;
        resetn   = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkReset("reset");
        @(posedge aclk); #1;
        resetn = 1'b1;

        // Contention from reset: src0 first, then src1 after one bubble.
        @(posedge aclk); #2;
        fire_cyc.delete(); fire_src.delete();
        applyStimulus(0, 32'h10, 3); applyStimulus(1, 32'h20, 3);
        expectPacket(0, 32'h10, 3);  expectPacket(1, 32'h20, 3);
        waitIdle("contention_rr", 200);
        checkOutput("fire_count", 64'(fire_cyc.size()), 64'd6);
        if (fire_cyc.size() == 6) begin
            checkOutput("in_pkt_consecutive", 64'(fire_cyc[2] - fire_cyc[0]), 64'd2);
            checkOutput("in_bubble_gap",      64'(fire_cyc[3] - fire_cyc[2]), 64'd2);
            checkOutput("second_grant_src",   64'(fire_src[3]), 64'd1);
        end

        // Pointer is now 2: src0 wins the next src0/src1 contention.
        applyStimulus(0, 32'h30, 2); applyStimulus(1, 32'h40, 2);
        expectPacket(0, 32'h30, 2);  expectPacket(1, 32'h40, 2);
        waitIdle("contention_again", 200);

        // Pointer is 2 again: src2 before src0 in round-robin, src0 first under strict priority.
        applyStimulus(0, 32'h50, 2); applyStimulus(2, 32'h60, 2);
`ifdef CMD_ARB_STRICT_PRIORITY_EN
        expectPacket(0, 32'h50, 2);  expectPacket(2, 32'h60, 2);
`else
        expectPacket(2, 32'h60, 2);  expectPacket(0, 32'h50, 2);
`endif
        waitIdle("wrap", 200);

        // Output stall pattern while src1 streams A1..A3.
        applyStimulus(1, 32'hA1, 3);
        expectPacket(1, 32'hA1, 3);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge aclk); #1;
            seen = m_tvalid;
        end
        checkOutput("stall_first_valid", 64'(seen), 64'd1);
        pat = 5'b11001;
        for (int k = 0; k < 5; k++) begin
            m_tready = pat[k];
            @(posedge aclk); #1;
        end
        m_tready = 1'b1;
        waitIdle("stall", 200);

        // src0 drops tvalid mid-packet while src1 waits; the grant must be held.
        applyStimulus(0, 32'h70, 4); applyStimulus(1, 32'h80, 2);
        expectPacket(0, 32'h70, 4);  expectPacket(1, 32'h80, 2);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge aclk); #2;
            seen = (src_q0.size() <= 3);
        end
        checkOutput("pause_started", 64'(seen), 64'd1);
        paused[0] = 1'b1;
        repeat (4) @(posedge aclk);
        #2;
        paused[0] = 1'b0;
        waitIdle("pause", 200);

        // Reset during beat 2 of a 5-beat packet.
        applyStimulus(0, 32'h90, 5);
        expectPacket(0, 32'h90, 5);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge aclk); #2;
            seen = (src_q0.size() <= 3);
        end
        checkOutput("midpkt_reached", 64'(seen), 64'd1);
        resetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        checkReset("rst_mid");
        src_q0.delete();
        exp_q.delete();
        @(posedge aclk); #1;
        resetn = 1'b1;
        applyStimulus(1, 32'hB0, 3);
        expectPacket(1, 32'hB0, 3);
        waitIdle("after_reset", 200);

        // Continuous single-beat requests from src0 and src1.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 32'hC0 + 32'(k), 1);
            applyStimulus(1, 32'hD0 + 32'(k), 1);
        end
`ifdef CMD_ARB_STRICT_PRIORITY_EN
        for (int k = 0; k < 4; k++) expectPacket(0, 32'hC0 + 32'(k), 1);
        for (int k = 0; k < 4; k++) expectPacket(1, 32'hD0 + 32'(k), 1);
`else
        for (int k = 0; k < 4; k++) begin
            expectPacket(0, 32'hC0 + 32'(k), 1);
            expectPacket(1, 32'hD0 + 32'(k), 1);
        end
`endif
        waitIdle("singles", 300);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
